piano_ctrl: RTL and testbench

//  Consumes ASCII keys from the UART RX FIFO and plays each as a timed note on the NCO.
//  - Maps each key to an FCW, drives the NCO for the current note length, echoes the key to the UART TX FIFO.
//  - Sits between the RX/TX FIFOs and the NCO inside z1top.
//  - '[' / ']' shorten / lengthen the note length and produce no sound.

---
 rtl/piano_pkg.sv | 24 ++
 rtl/piano_scale_rom.sv | 30 +++
 rtl/piano_ctrl.sv | 117 +++++++++++
 tb/tb_piano_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano controller: FSM encoding, length-control keys
// and note-length arithmetic helpers.
package piano_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_ECHO   = 3'd3,
    ST_PLAY   = 3'd4
  } state_t;

  localparam logic [7:0] KEY_SHORTER = 8'h5B;  // '['
  localparam logic [7:0] KEY_LONGER  = 8'h5D;  // ']'

  localparam int unsigned CYCLES_PER_SECOND_DEF = 32'd125_000_000;
  localparam int unsigned LEN_RESET             = 32'd4;

  // One note-length level lasts a quarter of a second.
  function automatic int unsigned len_step(input int unsigned cycles_per_second);
    return cycles_per_second / 32'd4;
  endfunction

endpackage

// File: rtl/piano_scale_rom.sv
// Combinational key-to-pitch table: ASCII key -> {hit, NCO frequency control word}.
// FCW = round(f * 2^24 / 122_070) for the 122_070 Hz NCO sample rate.
module piano_scale_rom #(
  parameter int unsigned FCW_WIDTH = 24
) (
  input  logic [7:0]           key,
  output logic                 hit,
  output logic [FCW_WIDTH-1:0] fcw_val
);

  // Bottom keyboard row plays the C4 major scale.
  always_comb begin
    hit     = 1'b1;
    fcw_val = '0;
    case (key)
      8'h7A:   fcw_val = FCW_WIDTH'(32'd35958);  // z  C4
      8'h78:   fcw_val = FCW_WIDTH'(32'd40360);  // x  D4
      8'h63:   fcw_val = FCW_WIDTH'(32'd45304);  // c  E4
      8'h76:   fcw_val = FCW_WIDTH'(32'd47998);  // v  F4
      8'h62:   fcw_val = FCW_WIDTH'(32'd53876);  // b  G4
      8'h6E:   fcw_val = FCW_WIDTH'(32'd60473);  // n  A4
      8'h6D:   fcw_val = FCW_WIDTH'(32'd67879);  // m  B4
      default: begin
        hit     = 1'b0;
        fcw_val = '0;
      end
    endcase
  end

endmodule

// File: rtl/piano_ctrl.sv
// Pops ASCII keys from the UART RX FIFO, echoes them to the TX FIFO and plays
// mapped keys on the NCO for the current note length; '[' / ']' adjust that length.
module piano_ctrl
  import piano_pkg::*;
#(
  parameter  int unsigned CYCLES_PER_SECOND = CYCLES_PER_SECOND_DEF,
  parameter  int unsigned FCW_WIDTH         = 24,
  parameter  int unsigned LEN_LEVELS        = 8,
  // Wide enough to hold LEN_LEVELS itself, since levels run 1..LEN_LEVELS.
  localparam int unsigned LEN_W             = $clog2(LEN_LEVELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ua_rx_data,
  input  logic                 ua_rx_empty,
  output logic                 ua_rx_rd_en,
  output logic [7:0]           ua_tx_din,
  input  logic                 ua_tx_full,
  output logic                 ua_tx_wr_en,
  output logic [FCW_WIDTH-1:0] fcw,
  output logic                 note_en,
  output logic [LEN_W-1:0]     len_level
);

  localparam int unsigned LEN_STEP = len_step(CYCLES_PER_SECOND);
  localparam int unsigned CNT_W    = $clog2(LEN_LEVELS * LEN_STEP);

  state_t               state_r;
  logic [CNT_W-1:0]     counter_r;
  logic                 hit_r;
  logic [FCW_WIDTH-1:0] fcw_val_r;
  logic [CNT_W-1:0]     last_cnt_s;
  logic                 rom_hit_s;
  logic [FCW_WIDTH-1:0] rom_fcw_s;

  piano_scale_rom #(
    .FCW_WIDTH (FCW_WIDTH)
  ) u_rom (
    .key     (ua_rx_data),
    .hit     (rom_hit_s),
    .fcw_val (rom_fcw_s)
  );

  // Final counter value of the current note: len_level steps of LEN_STEP cycles.
  always_comb begin
    last_cnt_s = CNT_W'((32'(len_level) * LEN_STEP) - 32'd1);
  end

  // Key handling FSM; ua_tx_din doubles as the latched key register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ua_rx_rd_en <= 1'b0;
      ua_tx_wr_en <= 1'b0;
      ua_tx_din   <= 8'h00;
      fcw         <= '0;
      note_en     <= 1'b0;
      len_level   <= LEN_W'(LEN_RESET);
      counter_r   <= '0;
      hit_r       <= 1'b0;
      fcw_val_r   <= '0;
    end else begin
      ua_rx_rd_en <= 1'b0;
      ua_tx_wr_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!ua_rx_empty) begin
            state_r     <= ST_READ;
            ua_rx_rd_en <= 1'b1;
          end
        end
        ST_READ: begin
          state_r <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          ua_tx_din <= ua_rx_data;
          hit_r     <= rom_hit_s;
          fcw_val_r <= rom_fcw_s;
          if ((ua_rx_data == KEY_LONGER) && (len_level != LEN_W'(LEN_LEVELS))) begin
            len_level <= len_level + 1'b1;
          end else if ((ua_rx_data == KEY_SHORTER) && (len_level != LEN_W'(1))) begin
            len_level <= len_level - 1'b1;
          end
          state_r <= ST_ECHO;
        end
        ST_ECHO: begin
          // A full TX FIFO holds us here; no sound until the echo is accepted.
          if (!ua_tx_full) begin
            ua_tx_wr_en <= 1'b1;
            if (hit_r) begin
              state_r   <= ST_PLAY;
              fcw       <= fcw_val_r;
              note_en   <= 1'b1;
              counter_r <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_PLAY: begin
          if (counter_r == last_cnt_s) begin
            state_r   <= ST_IDLE;
            fcw       <= '0;
            note_en   <= 1'b0;
            counter_r <= '0;
          end else begin
            counter_r <= counter_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piano_ctrl.sv
// Directed bench for piano_ctrl with a FIFO-driving harness and a timeline model
// of key handling that is checked against the outputs on every cycle.
module tb_piano_ctrl;

  localparam int unsigned CPS    = 800;
  localparam int unsigned STEP   = CPS / 4;
  localparam int unsigned LEVELS = 8;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic [7:0]  ua_rx_data  = 8'h00;
  logic        ua_rx_empty = 1'b1;
  logic        ua_rx_rd_en;
  logic [7:0]  ua_tx_din;
  logic        ua_tx_full  = 1'b0;
  logic        ua_tx_wr_en;
  logic [23:0] fcw;
  logic        note_en;
  logic [3:0]  len_level;

  always #5 clk = ~clk;

  piano_ctrl #(
    .CYCLES_PER_SECOND (CPS),
    .FCW_WIDTH         (24),
    .LEN_LEVELS        (LEVELS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ua_rx_data  (ua_rx_data),
    .ua_rx_empty (ua_rx_empty),
    .ua_rx_rd_en (ua_rx_rd_en),
    .ua_tx_din   (ua_tx_din),
    .ua_tx_full  (ua_tx_full),
    .ua_tx_wr_en (ua_tx_wr_en),
    .fcw         (fcw),
    .note_en     (note_en),
    .len_level   (len_level)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Pitch table from note frequencies: round(f * 2^24 / 122070); 0 = unmapped.
  function automatic int fcw_of(input byte unsigned k);
    string keys;
    real   freqs [7];
    keys  = "zxcvbnm";
    freqs = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88};
    for (int i = 0; i < 7; i++) begin
      if (keys[i] == k) return $rtoi(freqs[i] * 16777216.0 / 122070.0 + 0.5);
    end
    return 0;
  endfunction

  // ---------------- FIFO harness ----------------
  byte unsigned stim [256];
  int           wr_idx  = 0;
  int           rd_idx  = 0;
  int           wr_vis  = 0;
  int           cyc_cnt = 0;
  int           n_pops  = 0;
  byte unsigned tx_log [$];

  initial begin : fifo_p
    logic       pop;
    logic       push;
    logic [7:0] din;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      pop  = ua_rx_rd_en;
      push = ua_tx_wr_en;
      din  = ua_tx_din;
      #1;
      if (pop === 1'b1) begin
        n_pops++;
        if (rd_idx < wr_idx) begin
          ua_rx_data = stim[rd_idx];
          rd_idx++;
        end
      end
      if (push === 1'b1) tx_log.push_back(din);
      wr_vis      = wr_idx;
      ua_rx_empty = (rd_idx == wr_idx);
    end
  end

  // ---------------- behavioural model ----------------
  logic        e_rd, e_wr, e_note;
  logic [7:0]  e_din;
  int          e_fcw, e_len, m_len;
  int          m_idx = 0;
  bit          m_busy, m_avail, m_full;

  task automatic m_reset();
    e_rd = 1'b0; e_wr = 1'b0; e_note = 1'b0; e_din = 8'h00;
    e_fcw = 0; m_len = 4; e_len = 4; m_busy = 1'b0;
  endtask

  task automatic m_tick(output bit r);
    @(posedge clk);
    r       = (rst_n !== 1'b1);
    m_avail = (wr_vis > m_idx);
    m_full  = (ua_tx_full === 1'b1);
    #1;
  endtask

  // Per key: pop strobe, one cycle for the data, lookup, echo (waits on full), then the note.
  task automatic model_run();
    bit r;
    byte unsigned k;
    int f;
    forever begin
      m_busy = 1'b0;
      do begin
        m_tick(r); if (r) return;
        e_wr = 1'b0;
      end while (!m_avail);
      m_busy = 1'b1;
      e_rd   = 1'b1;
      m_tick(r); if (r) return;
      e_rd = 1'b0;
      k    = stim[m_idx];
      m_idx++;
      m_tick(r); if (r) return;
      e_din = k;
      if (k == 8'h5D) m_len = (m_len < LEVELS) ? m_len + 1 : LEVELS;
      else if (k == 8'h5B) m_len = (m_len > 1) ? m_len - 1 : 1;
      e_len = m_len;
      f     = fcw_of(k);
      do begin
        m_tick(r); if (r) return;
      end while (m_full);
      e_wr = 1'b1;
      if (f != 0) begin
        e_fcw  = f;
        e_note = 1'b1;
        for (int i = 0; i < m_len * STEP; i++) begin
          m_tick(r); if (r) return;
          e_wr = 1'b0;
        end
        e_fcw  = 0;
        e_note = 1'b0;
      end
    end
  endtask

  initial begin : model_p
    forever begin
      m_reset();
      wait (rst_n === 1'b1);
      model_run();
    end
  end

  // ---------------- per-cycle compare ----------------
  int   on_cyc   = 0;
  int   last_run = 0;
  int   note_log [$];

  initial begin : cmp_p
    logic [23:0] prev_fcw;
    int          run;
    prev_fcw = 24'd0;
    run      = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("rd_en", ua_rx_rd_en, e_rd);
        chk("wr_en", ua_tx_wr_en, e_wr);
        chk("tx_din", ua_tx_din, e_din);
        chk("fcw", fcw, e_fcw);
        chk("note_en", note_en, e_note);
        chk("len_level", len_level, e_len);
      end else begin
        chk("rst_rd_en", ua_rx_rd_en, 0);
        chk("rst_wr_en", ua_tx_wr_en, 0);
        chk("rst_tx_din", ua_tx_din, 0);
        chk("rst_fcw", fcw, 0);
        chk("rst_note_en", note_en, 0);
        chk("rst_len_level", len_level, 4);
      end
      if (fcw != 24'd0 && prev_fcw == 24'd0) begin
        on_cyc = cyc_cnt;
        note_log.push_back(int'(fcw));
        run = 0;
      end
      if (fcw != 24'd0) run++;
      if (fcw == 24'd0 && prev_fcw != 24'd0) last_run = run;
      prev_fcw = fcw;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input byte unsigned k);
    stim[wr_idx] = k;
    wr_idx++;
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int n;
    n = 0;
    cyc(2);
    while ((m_idx != wr_idx || m_busy) && n < budget) begin
      cyc(1);
      n++;
    end
    chk({nm, "_done"}, 32'(n < budget), 1);
    cyc(3);
  endtask

  initial begin : main_p
    int push_cyc;
    int pops0, tx0, notes0, n;

    // 1: reset, then idle with RX empty
    cyc(3);
    chk("t1_fcw", fcw, 0);
    chk("t1_note_en", note_en, 0);
    chk("t1_len", len_level, 4);
    chk("model_z", fcw_of(8'h7A), 35958);
    chk("model_x", fcw_of(8'h78), 40360);
    chk("model_c", fcw_of(8'h63), 45304);
    rst_n = 1'b1;
    cyc(100);
    chk("t1_pops", n_pops, 0);
    chk("t1_tx", tx_log.size(), 0);

    // 2: single 'z' at default length 4 -> 800 cycles
    push(8'h7A);
    push_cyc = cyc_cnt;
    wait_quiet(1200, "t2");
    chk("t2_pops", n_pops, 1);
    chk("t2_echo", tx_log[$], 8'h7A);
    chk("t2_note", note_log[$], 35958);
    chk("t2_cycles", last_run, 800);
    chk("t2_latency", on_cyc - push_cyc, 5);

    // 3: z,x,c back-to-back
    push(8'h7A); push(8'h78); push(8'h63);
    wait_quiet(3000, "t3");
    chk("t3_pops", n_pops, 4);
    chk("t3_echo0", tx_log[1], 8'h7A);
    chk("t3_echo1", tx_log[2], 8'h78);
    chk("t3_echo2", tx_log[3], 8'h63);
    chk("t3_note0", note_log[1], 35958);
    chk("t3_note1", note_log[2], 40360);
    chk("t3_note2", note_log[3], 45304);

    // 4: ']' x5 saturates at 8, 'x' lasts 1600; '[' x9 saturates at 1
    for (int i = 0; i < 5; i++) push(8'h5D);
    push(8'h78);
    wait_quiet(2200, "t4a");
    chk("t4_len_max", len_level, 8);
    chk("t4_note", note_log[$], 40360);
    chk("t4_cycles", last_run, 1600);
    chk("t4_notes", note_log.size(), 5);
    for (int i = 0; i < 9; i++) push(8'h5B);
    wait_quiet(200, "t4b");
    chk("t4_len_min", len_level, 1);
    chk("t4_echo_last", tx_log[$], 8'h5B);
    chk("t4_tx_count", tx_log.size(), 19);

    // 5: TX full stalls the echo, release lets 'c' play for 200 cycles
    ua_tx_full = 1'b1;
    tx0 = tx_log.size();
    push(8'h63);
    cyc(20);
    chk("t5_stall_tx", tx_log.size(), tx0);
    chk("t5_stall_fcw", fcw, 0);
    chk("t5_stall_pops", n_pops, 20);
    ua_tx_full = 1'b0;
    wait_quiet(400, "t5");
    chk("t5_echo", tx_log[$], 8'h63);
    chk("t5_note", note_log[$], 45304);
    chk("t5_cycles", last_run, 200);

    // 6: reset in the middle of a note; the popped key is not replayed
    push(8'h7A);
    n = 0;
    while (note_en !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("t6_started", note_en, 1);
    cyc(10);
    pops0  = n_pops;
    notes0 = note_log.size();
    rst_n  = 1'b0;
    #1;
    chk("t6_async_fcw", fcw, 0);
    chk("t6_async_note", note_en, 0);
    chk("t6_async_len", len_level, 4);
    cyc(3);
    rst_n = 1'b1;
    cyc(50);
    chk("t6_no_replay_pops", n_pops, pops0);
    chk("t6_no_replay_notes", note_log.size(), notes0);
    chk("t6_fcw_idle", fcw, 0);

    // 7: unmapped '?' is echoed and dropped
    tx0    = tx_log.size();
    notes0 = note_log.size();
    push(8'h3F);
    wait_quiet(50, "t7");
    chk("t7_echo", tx_log[$], 8'h3F);
    chk("t7_tx_count", tx_log.size(), tx0 + 1);
    chk("t7_no_note", note_log.size(), notes0);
    chk("t7_fcw", fcw, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
